// File: rtl/whack_round_controller.sv
// Whack-a-mole round sequencer: schedules moles from the LFSRs,
// judges per-hole hits and keeps score, lives and mole speed.
module whack_round_controller #(
  parameter int SLOT_TICKS    = 4,
  parameter int MIN_SLOT      = 1,
  parameter int GAP_TICKS     = 1,
  parameter int START_LIVES   = 3,
  parameter int SPEEDUP_EVERY = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] rand_pos,
  input  logic [3:0] rand_digit,
  input  logic [3:0] hit,
  output logic       next_rand,
  output logic       mole_valid,
  output logic [1:0] mole_pos,
  output logic [3:0] mole_digit,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       hit_flash
);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    UP,
    OVER
  } state_e;

  localparam logic [3:0] SLOT_INIT = 4'(SLOT_TICKS);
  localparam logic [3:0] SLOT_MIN  = 4'(MIN_SLOT);
  localparam logic [3:0] GAP_INIT  = 4'(GAP_TICKS);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0] SPD_MASK  = 8'(SPEEDUP_EVERY - 1);

  state_e     state_q, state_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] slot_cnt_q, slot_cnt_d;
  logic [3:0] slot_len_q, slot_len_d;
  logic [1:0] last_pos_q, last_pos_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic       mole_valid_q, mole_valid_d;
  logic [1:0] mole_pos_q, mole_pos_d;
  logic [3:0] mole_digit_q, mole_digit_d;
  logic       game_over_q, game_over_d;
  logic       next_rand_q, next_rand_d;
  logic       hit_flash_q, hit_flash_d;

  logic [3:0] pos_oh;
  logic       wrong;
  logic       correct;
  logic       timeout;
  logic       end_mole;
  logic [7:0] score_inc;
  logic [1:0] pick_pos;

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    slot_cnt_d   = slot_cnt_q;
    slot_len_d   = slot_len_q;
    last_pos_d   = last_pos_q;
    score_d      = score_q;
    lives_d      = lives_q;
    mole_valid_d = mole_valid_q;
    mole_pos_d   = mole_pos_q;
    mole_digit_d = mole_digit_q;
    game_over_d  = game_over_q;
    next_rand_d  = 1'b0;
    hit_flash_d  = 1'b0;
    end_mole     = 1'b0;

    pos_oh    = 4'b0001 << mole_pos_q;
    wrong     = |(hit & ~pos_oh);
    correct   = !wrong && |(hit & pos_oh);
    timeout   = tick && (slot_cnt_q == 4'd1);
    score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    // Never show the same hole twice in a row.
    pick_pos  = (rand_pos == last_pos_q) ? rand_pos + 2'd1 : rand_pos;

    unique case (state_q)
      IDLE, OVER: begin
        mole_valid_d = 1'b0;
        if (start) begin
          score_d     = 8'd0;
          lives_d     = LIVES_INIT;
          slot_len_d  = SLOT_INIT;
          game_over_d = 1'b0;
          gap_cnt_d   = GAP_INIT;
          state_d     = GAP;
        end
      end
      GAP: begin
        mole_valid_d = 1'b0;
        if (tick) begin
          if (gap_cnt_q == 4'd1) begin
            state_d      = UP;
            mole_valid_d = 1'b1;
            mole_pos_d   = pick_pos;
            mole_digit_d = rand_digit;
            last_pos_d   = pick_pos;
            slot_cnt_d   = slot_len_q;
            next_rand_d  = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end
      end
      UP: begin
        if (wrong) begin
          lives_d  = lives_q - 2'd1;
          end_mole = 1'b1;
        end else if (correct) begin
          score_d     = score_inc;
          hit_flash_d = 1'b1;
          end_mole    = 1'b1;
          if ((score_inc & SPD_MASK) == 8'd0 && score_inc != 8'd0 &&
              slot_len_q > SLOT_MIN)
            slot_len_d = slot_len_q - 4'd1;
        end else if (timeout) begin
          lives_d  = lives_q - 2'd1;
          end_mole = 1'b1;
        end else if (tick) begin
          slot_cnt_d = slot_cnt_q - 4'd1;
        end
        if (end_mole) begin
          mole_valid_d = 1'b0;
          gap_cnt_d    = GAP_INIT;
          if (lives_d == 2'd0) begin
            state_d     = OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      gap_cnt_q    <= 4'd0;
      slot_cnt_q   <= 4'd0;
      slot_len_q   <= SLOT_INIT;
      last_pos_q   <= 2'd0;
      score_q      <= 8'd0;
      lives_q      <= 2'd0;
      mole_valid_q <= 1'b0;
      mole_pos_q   <= 2'd0;
      mole_digit_q <= 4'd0;
      game_over_q  <= 1'b0;
      next_rand_q  <= 1'b0;
      hit_flash_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      slot_cnt_q   <= slot_cnt_d;
      slot_len_q   <= slot_len_d;
      last_pos_q   <= last_pos_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      mole_valid_q <= mole_valid_d;
      mole_pos_q   <= mole_pos_d;
      mole_digit_q <= mole_digit_d;
      game_over_q  <= game_over_d;
      next_rand_q  <= next_rand_d;
      hit_flash_q  <= hit_flash_d;
    end
  end

  assign next_rand  = next_rand_q;
  assign mole_valid = mole_valid_q;
  assign mole_pos   = mole_pos_q;
  assign mole_digit = mole_digit_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;
  assign hit_flash  = hit_flash_q;

endmodule
